crc_fcs_append: RTL

Transmit-side frame check sequence (FCS) inserter. It accepts a byte stream framed with valid/ready/last, passes each byte through unchanged, and appends the 4-byte complemented LSB-first CRC-32 after the last byte. It sits between the MAC transmit framer and the line encoder. It computes the CRC itself with the same bit-serial-unrolled LSB update used by the receive-side CRC register.

---
 rtl/crc_pkg.sv | 27 ++
 rtl/crc_byte_update.sv | 35 +++
 rtl/crc_fcs_append.sv | 186 ++++++++++++++++++
 3 files changed

// File: rtl/crc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : crc_pkg
//  Description : Shared constants and types for the CRC-32 transmit FCS
//                inserter and the receive-side CRC checker.
//                  CRC32_POLY      reflected generator polynomial
//                  CRC32_INIT      register value at the start of a frame
//                  CRC32_RESIDUE   remainder left after data+FCS on receive
//                  ETH_MIN_PAYLOAD minimum payload length before the FCS
//                  fcs_state_t     inserter state encoding
//  Revision    : 1.0 - initial release
// ============================================================================
package crc_pkg;

    localparam logic [31:0] CRC32_POLY      = 32'hEDB88320;
    localparam logic [31:0] CRC32_INIT      = 32'hFFFFFFFF;
    localparam logic [31:0] CRC32_RESIDUE   = 32'hDEBB20E3;
    localparam int          ETH_MIN_PAYLOAD = 60;

    typedef enum logic [1:0] {
        DATA = 2'd0,
        PAD  = 2'd1,
        FCS  = 2'd2
    } fcs_state_t;

endpackage : crc_pkg
`default_nettype wire

// File: rtl/crc_byte_update.sv
`default_nettype none
// ============================================================================
//  Module      : crc_byte_update
//  Description : Purely combinational one-byte update of a reflected
//                (LSB-first) CRC register: eight chained single-bit steps,
//                data bit 0 first. Shared with the receive-side checker.
//  Ports       : acc  [W-1:0]  current CRC register value
//                d    [7:0]    data byte
//                next [W-1:0]  CRC register value after absorbing d
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_byte_update
    import crc_pkg::*;
#(
    parameter int           W = 32,
    parameter logic [W-1:0] P = CRC32_POLY
) (
    input  logic [W-1:0] acc,
    input  logic [7:0]   d,
    output logic [W-1:0] next
);

    always_comb begin
        next = acc;
        for (int i = 0; i < 8; i++) begin
            if (next[0] ^ d[i]) begin
                next = (next >> 1) ^ P;
            end else begin
                next = next >> 1;
            end
        end
    end

endmodule : crc_byte_update
`default_nettype wire

// File: rtl/crc_fcs_append.sv
`default_nettype none
// ============================================================================
//  Module      : crc_fcs_append
//  Description : Transmit-side FCS inserter. Passes a valid/ready/last byte
//                stream through one output register stage and appends the
//                complemented LSB-first CRC-32 (4 bytes, low byte first)
//                after the last payload byte of every frame.
//                Optional feature macro CRC_FCS_PAD_EN: when defined, frames
//                shorter than MIN_LEN bytes are zero-padded up to MIN_LEN
//                before the FCS, and the pad bytes are covered by the CRC.
//  Ports       : clk, reset   clock, asynchronous active-high reset
//                s_valid/s_ready/s_data[7:0]/s_last   upstream byte stream
//                m_valid/m_ready/m_data[7:0]/m_last   downstream byte stream
//                                                     (m_last on final FCS)
//  Revision    : 1.0 - initial release
// ============================================================================
module crc_fcs_append
    import crc_pkg::*;
#(
    parameter int           W       = 32,
    parameter logic [W-1:0] P       = CRC32_POLY,
    parameter int           MIN_LEN = ETH_MIN_PAYLOAD
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       s_valid,
    output logic       s_ready,
    input  logic [7:0] s_data,
    input  logic       s_last,
    output logic       m_valid,
    input  logic       m_ready,
    output logic [7:0] m_data,
    output logic       m_last
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter sanity
    // ------------------------------------------------------------------
    if (W != 32) begin : g_width_check
        $error("crc_fcs_append: only W=32 is supported");
    end

    if (MIN_LEN < 1) begin : g_min_len_check
        $error("crc_fcs_append: MIN_LEN must be at least 1");
    end

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    fcs_state_t   state;
    logic [W-1:0] crc;
    logic [1:0]   k;

    // The output register can take a new byte when empty or being drained.
    logic slot_free;
    assign slot_free = !m_valid || m_ready;
    assign s_ready   = (state == DATA) && slot_free;

    logic [7:0]   upd_byte;
    logic [W-1:0] crc_next;

`ifdef CRC_FCS_PAD_EN
    // Byte counter, saturating at MIN_LEN. Compares are done one bit
    // wider than the counter so a saturated count can never wrap.
    localparam int              CW          = $clog2(MIN_LEN + 1);
    localparam int              CW1         = CW + 1;
    localparam logic [CW1-1:0]  MIN_LEN_X   = CW1'(MIN_LEN);

    logic [CW-1:0]  cnt;
    logic [CW1-1:0] cnt_inc;
    logic           pad_needed;
    logic           pad_done;

    assign cnt_inc    = {1'b0, cnt} + CW1'(1);
    assign pad_needed = (cnt_inc < MIN_LEN_X);
    assign pad_done   = (cnt_inc >= MIN_LEN_X);

    // Pad bytes are zeros and enter the CRC exactly like payload.
    assign upd_byte   = (state == PAD) ? 8'h00 : s_data;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (slot_free) begin
            case (state)
                DATA: begin
                    if (s_valid && pad_needed) begin
                        cnt <= cnt_inc[CW-1:0];
                    end else if (s_valid && (cnt_inc == MIN_LEN_X)) begin
                        cnt <= cnt_inc[CW-1:0];
                    end
                end
                PAD: begin
                    cnt <= cnt_inc[CW-1:0];
                end
                FCS: begin
                    if (k == 2'd3) begin
                        cnt <= '0;
                    end
                end
                default: begin
                    cnt <= '0;
                end
            endcase
        end
    end
`else
    assign upd_byte = s_data;
`endif

    crc_byte_update #(
        .W (W),
        .P (P)
    ) u_crc_byte_update (
        .acc  (crc),
        .d    (upd_byte),
        .next (crc_next)
    );

    // ------------------------------------------------------------------
    // Main FSM with the output register. Everything advances only on a
    // free slot, so downstream backpressure freezes the whole datapath.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= DATA;
            crc     <= CRC32_INIT;
            k       <= 2'd0;
            m_valid <= 1'b0;
            m_data  <= 8'h00;
            m_last  <= 1'b0;
        end else if (slot_free) begin
            case (state)
                DATA: begin
                    m_last <= 1'b0;
                    if (s_valid) begin
                        m_valid <= 1'b1;
                        m_data  <= s_data;
                        crc     <= crc_next;
                        if (s_last) begin
`ifdef CRC_FCS_PAD_EN
                            state <= pad_needed ? PAD : FCS;
`else
                            state <= FCS;
`endif
                        end
                    end else begin
                        m_valid <= 1'b0;
                    end
                end
`ifdef CRC_FCS_PAD_EN
                PAD: begin
                    m_valid <= 1'b1;
                    m_data  <= 8'h00;
                    m_last  <= 1'b0;
                    crc     <= crc_next;
                    if (pad_done) begin
                        state <= FCS;
                    end
                end
`endif
                FCS: begin
                    // CRC is held here; the complemented register is sent
                    // low byte first.
                    m_valid <= 1'b1;
                    m_data  <= ~crc[{k, 3'b000} +: 8];
                    m_last  <= (k == 2'd3);
                    if (k == 2'd3) begin
                        crc   <= CRC32_INIT;
                        k     <= 2'd0;
                        state <= DATA;
                    end else begin
                        k <= k + 2'd1;
                    end
                end
                default: begin
                    state   <= DATA;
                    m_valid <= 1'b0;
                    m_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule : crc_fcs_append
`default_nettype wire
